// File: rtl/uart_echo_buffer_pkg.sv
// Shared definitions for the UART echo buffer slice.
//   echo_state_e        : batch-mode state (Fill collects, Drain retransmits)
//   DefaultDepth        : default FIFO depth
//   DefaultMessageBytes : default batch message length
package uart_echo_pkg;

    localparam int unsigned StateBits = 1;

    typedef enum logic [StateBits-1:0] {
        StateFill  = 1'b0,
        StateDrain = 1'b1
    } echo_state_e;

    localparam int unsigned DefaultDepth        = 8;
    localparam int unsigned DefaultMessageBytes = 4;

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Byte handshake between receiver, echo buffer and transmitter.
//   rx_byte / rx_byte_valid   : byte offered by the receiver
//   rx_byte_done_out          : one-cycle ack, byte consumed
//   tx_byte_out               : byte for the transmitter
//   tx_byte_valid_out         : one-cycle transmit request
//   tx_byte_done              : transmitter idle/ready
// master = receiver/transmitter side, slave = echo buffer.
interface uart_echo_buffer_if;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_byte_done_out;
    logic [7:0] tx_byte_out;
    logic       tx_byte_valid_out;
    logic       tx_byte_done;

    modport master (
        output rx_byte, rx_byte_valid, tx_byte_done,
        input  rx_byte_done_out, tx_byte_out, tx_byte_valid_out
    );

    modport slave (
        input  rx_byte, rx_byte_valid, tx_byte_done,
        output rx_byte_done_out, tx_byte_out, tx_byte_valid_out
    );
endinterface

// File: rtl/uart_echo_buffer_byte_fifo.sv
// Byte FIFO with first-word-fall-through head.
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/level)
//   push       : write push_data (caller guarantees not full)
//   pop        : discard head (caller guarantees not empty)
//   head       : current oldest entry, valid while !empty
//   full/empty : level == Depth / level == 0
//   level      : occupancy, 0..Depth
module byte_fifo
    import uart_echo_pkg::*;
#(
    parameter int unsigned Depth = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               push_data,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);
    localparam int unsigned PtrBits = $clog2(Depth);
    localparam logic [PtrBits-1:0] PtrOne    = PtrBits'(1);
    localparam logic [PtrBits:0]   LevelOne  = (PtrBits + 1)'(1);
    localparam logic [PtrBits:0]   LevelFull = (PtrBits + 1)'(Depth);

    logic [7:0]         mem [Depth];
    logic [PtrBits-1:0] wr_ptr;
    logic [PtrBits-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            case ({push, pop})
                2'b10:   level <= level + LevelOne;
                2'b01:   level <= level - LevelOne;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LevelFull);
    assign empty = (level == '0);

endmodule

// File: rtl/uart_echo_buffer.sv
// Byte echo engine: buffers received bytes, XORs them with XorMask and
// retransmits them, either per byte (stream) or per MessageBytes message
// (batch).
//   clk, rst           : clock, synchronous active-high reset
//   uart               : receiver/transmitter handshake (slave side)
//   fifo_level_out     : FIFO occupancy
//   messages_done_out  : completed messages (every pop in stream mode); wraps
//   busy_out           : draining, or bytes still buffered
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int unsigned Depth        = DefaultDepth,
    parameter int unsigned MessageBytes = DefaultMessageBytes,
    parameter int unsigned BatchMode    = 1,
    parameter logic [7:0]  XorMask      = 8'h00,
    parameter int unsigned CountBits    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_echo_buffer_if.slave      uart,
    output logic [$clog2(Depth):0] fifo_level_out,
    output logic [CountBits-1:0]   messages_done_out,
    output logic                   busy_out
);
    localparam int unsigned LevelBits = $clog2(Depth) + 1;
    localparam logic [LevelBits-1:0] LevelOne = LevelBits'(1);
    localparam logic [LevelBits-1:0] MsgLevel = LevelBits'(MessageBytes);
    localparam logic [LevelBits-1:0] LastSent = LevelBits'(MessageBytes - 1);
    localparam logic [CountBits-1:0] CountOne = CountBits'(1);

    echo_state_e          state;
    logic [LevelBits-1:0] sent;
    logic [LevelBits-1:0] level;
    logic [LevelBits-1:0] level_after;
    logic [7:0]           head;
    logic                 full;
    logic                 empty;
    logic                 armed;
    logic                 push;
    logic                 pop;
    logic                 drain_en;

    byte_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (uart.rx_byte),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // A byte held valid across its ack is consumed once: 'armed' is only
    // restored after the receiver drops valid.
    always_comb begin
        drain_en = (BatchMode == 0) || (state == StateDrain);
        push     = uart.rx_byte_valid && armed && !uart.rx_byte_done_out && !full;
        pop      = drain_en && !empty && uart.tx_byte_done && !uart.tx_byte_valid_out;
        case ({push, pop})
            2'b10:   level_after = level + LevelOne;
            2'b01:   level_after = level - LevelOne;
            default: level_after = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= StateFill;
            sent                   <= '0;
            armed                  <= 1'b1;
            uart.rx_byte_done_out  <= 1'b0;
            uart.tx_byte_valid_out <= 1'b0;
            uart.tx_byte_out       <= 8'hff;
            messages_done_out      <= '0;
        end else begin
            uart.rx_byte_done_out  <= push;
            uart.tx_byte_valid_out <= pop;
            armed                  <= !uart.rx_byte_valid || (armed && !push);
            if (pop) begin
                uart.tx_byte_out <= head ^ XorMask;
            end
            if (BatchMode == 0) begin
                if (pop) begin
                    messages_done_out <= messages_done_out + CountOne;
                end
            end else begin
                case (state)
                    StateFill: begin
                        // level_after includes this cycle's push; also
                        // re-enters Drain when a full message is already queued.
                        if (level_after >= MsgLevel) begin
                            state <= StateDrain;
                            sent  <= '0;
                        end
                    end
                    StateDrain: begin
                        if (pop) begin
                            if (sent == LastSent) begin
                                state             <= StateFill;
                                messages_done_out <= messages_done_out + CountOne;
                            end else begin
                                sent <= sent + LevelOne;
                            end
                        end
                    end
                    default: state <= StateFill;
                endcase
            end
        end
    end

    assign fifo_level_out = level;
    assign busy_out       = (state == StateDrain) || !empty;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed + randomized bench for uart_echo_buffer. Three instances:
//   k=0 batch  (Depth 8, MessageBytes 4, mask 00)
//   k=1 stream (Depth 8, mask ff, CountBits 2)
//   k=2 batch  (Depth 4, MessageBytes 4, mask 3c) for backpressure
// Expected bytes come from queues of the bytes sent, XORed with the mask.
module tb_uart_echo_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_echo_buffer_if ifb ();
    uart_echo_buffer_if ifs ();
    uart_echo_buffer_if ifp ();

    logic [3:0]  lvl_b, lvl_s;
    logic [2:0]  lvl_p;
    logic [15:0] msg_b, msg_p;
    logic [1:0]  msg_s;
    logic        busy_b, busy_s, busy_p;

    uart_echo_buffer #(.Depth(8), .MessageBytes(4), .BatchMode(1), .XorMask(8'h00), .CountBits(16)) u_b (
        .clk(clk), .rst(rst), .uart(ifb.slave),
        .fifo_level_out(lvl_b), .messages_done_out(msg_b), .busy_out(busy_b));
    uart_echo_buffer #(.Depth(8), .MessageBytes(4), .BatchMode(0), .XorMask(8'hff), .CountBits(2)) u_s (
        .clk(clk), .rst(rst), .uart(ifs.slave),
        .fifo_level_out(lvl_s), .messages_done_out(msg_s), .busy_out(busy_s));
    uart_echo_buffer #(.Depth(4), .MessageBytes(4), .BatchMode(1), .XorMask(8'h3c), .CountBits(16)) u_p (
        .clk(clk), .rst(rst), .uart(ifp.slave),
        .fifo_level_out(lvl_p), .messages_done_out(msg_p), .busy_out(busy_p));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ack_n   [3] = '{0, 0, 0};
    int tx_n    [3] = '{0, 0, 0};
    int ack_cyc [3] = '{0, 0, 0};
    int tx_cyc  [3] = '{0, 0, 0};
    logic [7:0] txq_b[$], txq_s[$], txq_p[$];
    logic [7:0] exp_b[$], exp_s[$], exp_p[$];
    int msgq_s[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; records acks and transmit pulses of all instances.
    task automatic tick();
        logic [2:0] td;
        td = {ifp.tx_byte_done, ifs.tx_byte_done, ifb.tx_byte_done};
        @(posedge clk);
        #1;
        cyc++;
        if (ifb.rx_byte_done_out) begin ack_n[0]++; ack_cyc[0] = cyc; end
        if (ifs.rx_byte_done_out) begin ack_n[1]++; ack_cyc[1] = cyc; end
        if (ifp.rx_byte_done_out) begin ack_n[2]++; ack_cyc[2] = cyc; end
        if (ifb.tx_byte_valid_out) begin
            tx_n[0]++; tx_cyc[0] = cyc; txq_b.push_back(ifb.tx_byte_out);
            chk("b_pop_needs_ready", td[0], 1);
        end
        if (ifs.tx_byte_valid_out) begin
            tx_n[1]++; tx_cyc[1] = cyc; txq_s.push_back(ifs.tx_byte_out);
            msgq_s.push_back(int'(msg_s));
            chk("s_pop_needs_ready", td[1], 1);
        end
        if (ifp.tx_byte_valid_out) begin
            tx_n[2]++; tx_cyc[2] = cyc; txq_p.push_back(ifp.tx_byte_out);
            chk("p_pop_needs_ready", td[2], 1);
        end
    endtask

    task automatic set_rx(input int k, input logic v, input logic [7:0] b);
        case (k)
            0: begin ifb.rx_byte_valid = v; ifb.rx_byte = b; end
            1: begin ifs.rx_byte_valid = v; ifs.rx_byte = b; end
            default: begin ifp.rx_byte_valid = v; ifp.rx_byte = b; end
        endcase
    endtask

    task automatic set_txd(input int k, input logic d);
        case (k)
            0: ifb.tx_byte_done = d;
            1: ifs.tx_byte_done = d;
            default: ifp.tx_byte_done = d;
        endcase
    endtask

    // Offer a byte until acked, then drop valid for one cycle.
    task automatic send(input int k, input logic [7:0] b, output int ack_at);
        int n0;
        int budget;
        n0 = ack_n[k];
        budget = 0;
        set_rx(k, 1'b1, b);
        while (ack_n[k] == n0 && budget < 200) begin
            tick();
            budget++;
        end
        chk("ack_arrives", ack_n[k] - n0, 1);
        ack_at = ack_cyc[k];
        set_rx(k, 1'b0, b);
        tick();
    endtask

    task automatic wait_tx(input int k, input int n);
        int budget;
        budget = 0;
        while (tx_n[k] < n && budget < 300) begin
            tick();
            budget++;
        end
        chk("tx_arrives", tx_n[k] >= n, 1);
    endtask

    initial begin
        int a;
        int prev;
        int base;
        logic [7:0] b;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_rx(k, 1'b0, 8'h00);
            set_txd(k, 1'b1);
        end
        tick();
        tick();
        chk("rst_tx_byte_b", ifb.tx_byte_out, 8'hff);
        chk("rst_tx_byte_s", ifs.tx_byte_out, 8'hff);
        chk("rst_tx_valid_b", ifb.tx_byte_valid_out, 0);
        chk("rst_rx_done_b", ifb.rx_byte_done_out, 0);
        chk("rst_level_b", lvl_b, 0);
        chk("rst_msgs_b", msg_b, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        tick();

        // Batch: nothing leaves before the 4th byte, then 4 spaced pulses.
        for (int i = 1; i <= 3; i++) send(0, 8'(i), a);
        repeat (5) tick();
        chk("b_hold_until_full_msg", tx_n[0], 0);
        chk("b_level_3", lvl_b, 3);
        send(0, 8'h04, a);
        wait_tx(0, 1);
        chk("b_first_latency", tx_cyc[0] - a, 1);
        for (int j = 2; j <= 4; j++) begin
            prev = tx_cyc[0];
            wait_tx(0, j);
            chk("b_pulse_gap", tx_cyc[0] - prev, 2);
        end
        for (int j = 0; j < 4; j++) chk("b_byte_order", txq_b[j], 8'(j + 1));
        chk("b_msgs_1", msg_b, 1);
        chk("b_level_0", lvl_b, 0);
        chk("b_idle", busy_b, 0);

        // Batch, random bytes and random transmitter readiness: two messages.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                set_txd(0, 1'($urandom_range(0, 1)));
                tick();
            end
            b = 8'($urandom);
            exp_b.push_back(b);
            set_txd(0, 1'($urandom_range(0, 1)));
            send(0, b, a);
        end
        set_txd(0, 1'b1);
        wait_tx(0, 12);
        for (int j = 0; j < 8; j++) chk("b_rand_byte", txq_b[4 + j], exp_b[j]);
        chk("b_msgs_3", msg_b, 3);
        chk("b_rand_level_0", lvl_b, 0);

        // Stream, mask ff: 2-cycle valid-to-valid, counter per byte, wraps at 4.
        send(1, 8'h00, a);
        wait_tx(1, 1);
        chk("s_latency_1", tx_cyc[1] - a, 1);
        send(1, 8'h5a, a);
        wait_tx(1, 2);
        chk("s_latency_2", tx_cyc[1] - a, 1);
        chk("s_byte_0", txq_s[0], 8'hff);
        chk("s_byte_1", txq_s[1], 8'ha5);
        chk("s_msgs_2", msg_s, 2);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_s.push_back(b ^ 8'hff);
            set_txd(1, 1'($urandom_range(0, 1)));
            send(1, b, a);
        end
        set_txd(1, 1'b1);
        wait_tx(1, 5);
        for (int j = 0; j < 3; j++) chk("s_rand_byte", txq_s[2 + j], exp_s[j]);
        for (int j = 0; j < 5; j++) chk("s_msg_wrap", msgq_s[j], (j + 1) % 4);

        // Backpressure: Depth 4, transmitter busy, 5th byte must wait.
        set_txd(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_p.push_back(b ^ 8'h3c);
            send(2, b, a);
        end
        b = 8'($urandom);
        exp_p.push_back(b ^ 8'h3c);
        set_rx(2, 1'b1, b);
        repeat (10) tick();
        chk("p_no_ack_when_full", ack_n[2], 4);
        chk("p_level_full", lvl_p, 4);
        chk("p_busy", busy_p, 1);
        chk("p_no_tx_while_blocked", tx_n[2], 0);
        set_txd(2, 1'b1);
        wait_tx(2, 1);
        prev = 0;
        while (ack_n[2] < 5 && prev < 10) begin
            tick();
            prev++;
        end
        chk("p_unblock_window", (ack_cyc[2] - tx_cyc[2] >= 1) && (ack_cyc[2] - tx_cyc[2] <= 2), 1);
        set_rx(2, 1'b0, b);
        tick();
        wait_tx(2, 4);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_p.push_back(b ^ 8'h3c);
            send(2, b, a);
        end
        wait_tx(2, 8);
        for (int j = 0; j < 8; j++) chk("p_byte", txq_p[j], exp_p[j]);
        chk("p_msgs_2", msg_p, 2);

        // Valid held for 10 cycles with one byte: a single push.
        base = ack_n[0];
        set_rx(0, 1'b1, 8'h77);
        repeat (10) tick();
        set_rx(0, 1'b0, 8'h00);
        tick();
        chk("hold_one_ack", ack_n[0] - base, 1);
        chk("hold_level_1", lvl_b, 1);

        // Reset in the middle of a batch drain.
        base = tx_n[0];
        exp_b.delete();
        exp_b.push_back(8'h77);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            send(0, b, a);
        end
        wait_tx(0, base + 2);
        chk("mid_byte_0", txq_b[base], exp_b[0]);
        chk("mid_byte_1", txq_b[base + 1], exp_b[1]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", lvl_b, 0);
        chk("mid_rst_msgs", msg_b, 0);
        chk("mid_rst_busy", busy_b, 0);
        chk("mid_rst_tx_byte", ifb.tx_byte_out, 8'hff);
        chk("mid_rst_tx_valid", ifb.tx_byte_valid_out, 0);
        chk("mid_rst_rx_done", ifb.rx_byte_done_out, 0);
        repeat (10) tick();
        chk("mid_rst_no_more_tx", tx_n[0], base + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
